// File: rtl/msi_cache_ctrl_pkg.sv
// rtl/msi_cache_ctrl_pkg.sv - shared types and constants for the MSI cache controller
package msi_cache_ctrl_pkg;

    typedef enum logic [1:0] {
        INVALID  = 2'd0,
        SHARED   = 2'd1,
        MODIFIED = 2'd2
    } blk_state_t;

    typedef logic [3:0] ctrl_state_t;

    localparam ctrl_state_t S_IDLE  = 4'd0;
    localparam ctrl_state_t S_CMP   = 4'd1;
    localparam ctrl_state_t S_ARB   = 4'd2;
    localparam ctrl_state_t S_UPG   = 4'd3;
    localparam ctrl_state_t S_WB    = 4'd4;
    localparam ctrl_state_t S_FILL  = 4'd5;
    localparam ctrl_state_t S_WRITE = 4'd6;
    localparam ctrl_state_t S_INV   = 4'd7;
    localparam ctrl_state_t S_DONE  = 4'd8;

    // Victim line address: resident tag over the shared 6-bit index.
    function automatic logic [10:0] victim_line(input logic [4:0] tag, input logic [5:0] index);
        return {tag, index};
    endfunction

endpackage

// File: rtl/msi_cache_ctrl_word_merge.sv
// rtl/msi_cache_ctrl_word_merge.sv - inserts one 16-bit word into a 64-bit line
module msi_cache_ctrl_word_merge (
    input  logic [63:0] line,
    input  logic [15:0] word,
    input  logic [1:0]  sel,
    output logic [63:0] merged
);

    always_comb begin
        merged = line;
        merged[{sel, 4'b0000} +: 16] = word;
    end

endmodule

// File: rtl/msi_cache_ctrl.sv
// rtl/msi_cache_ctrl.sv - per-core MSI controller sequencing cache, memory and coherence bus
module msi_cache_ctrl
    import msi_cache_ctrl_pkg::*;
#(
    parameter int MEM_TO = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [12:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rdy,
    output logic        cpu_err,
    output logic [10:0] c_addr,
    output logic        c_re,
    output logic        c_we,
    output logic [1:0]  c_wstate,
    output logic [63:0] c_wdata,
    input  logic        c_hit,
    input  logic        c_dirty,
    input  logic [1:0]  c_rstate,
    input  logic [63:0] c_rdata,
    input  logic [4:0]  c_tag,
    output logic        mem_re,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        inv_out,
    output logic [10:0] inv_addr
);

    localparam int CW = $clog2(MEM_TO + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(MEM_TO - 1);

    ctrl_state_t   state, state_d, arb_next_q;
    logic [10:0]   line_q;
    logic [1:0]    wsel_q;
    logic [15:0]   wdata_q;
    logic          is_wr_q;
    logic [63:0]   buf_q;
    logic [4:0]    tag_q;
    logic          bus_req_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic          mem_state;
    logic          timeout;
    logic [63:0]   merge_in;
    logic [63:0]   merged;

    assign mem_state = (state == S_WB) || (state == S_FILL);
    assign timeout   = mem_state && !mem_rdy && (cnt_q == TO_LAST);
    assign merge_in  = (state == S_FILL) ? mem_rdata : buf_q;

    msi_cache_ctrl_word_merge u_merge (
        .line   (merge_in),
        .word   (wdata_q),
        .sel    (wsel_q),
        .merged (merged)
    );

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (cpu_rd || cpu_wr) state_d = S_CMP;
            S_CMP: begin
                if (c_hit && !is_wr_q)               state_d = S_DONE;
                else if (c_hit && c_rstate == MODIFIED) state_d = S_WRITE;
                else                                 state_d = S_ARB;
            end
            S_ARB:   if (bus_gnt) state_d = arb_next_q;
            S_UPG:   state_d = S_WRITE;
            S_WB:    if (mem_rdy) state_d = S_FILL; else if (timeout) state_d = S_DONE;
            S_FILL:  if (mem_rdy) state_d = is_wr_q ? S_INV : S_DONE;
                     else if (timeout) state_d = S_DONE;
            S_WRITE: state_d = S_DONE;
            S_INV:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            arb_next_q <= S_IDLE;
            line_q     <= '0;
            wsel_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            buf_q      <= '0;
            tag_q      <= '0;
            bus_req_q  <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state <= state_d;
            cnt_q <= (state_d != state) ? '0 : (mem_state ? cnt_q + CW'(1) : cnt_q);
            if (state == S_IDLE && (cpu_rd || cpu_wr)) begin
                line_q  <= cpu_addr[12:2];
                wsel_q  <= cpu_addr[1:0];
                wdata_q <= cpu_wdata;
                is_wr_q <= cpu_wr;
                err_q   <= 1'b0;
            end
            if (state == S_CMP) begin
                buf_q      <= c_rdata;
                tag_q      <= c_tag;
                arb_next_q <= c_hit ? S_UPG : (c_dirty ? S_WB : S_FILL);
                if (state_d == S_ARB) bus_req_q <= 1'b1;
            end
            if (state == S_FILL && mem_rdy) buf_q <= mem_rdata;
            if (timeout) err_q <= 1'b1;
            if (state == S_DONE) bus_req_q <= 1'b0;
        end
    end

    // Cache write on fill is qualified by the single-cycle mem_rdy pulse.
    always_comb begin
        c_we     = 1'b0;
        c_wstate = INVALID;
        c_wdata  = '0;
        if (state == S_WRITE) begin
            c_we     = 1'b1;
            c_wstate = MODIFIED;
            c_wdata  = merged;
        end else if (state == S_FILL && mem_rdy) begin
            c_we     = 1'b1;
            c_wstate = is_wr_q ? MODIFIED : SHARED;
            c_wdata  = is_wr_q ? merged : mem_rdata;
        end
    end

    assign c_addr    = line_q;
    assign c_re      = (state == S_CMP);
    assign mem_re    = (state == S_FILL);
    assign mem_we    = (state == S_WB);
    assign mem_addr  = (state == S_WB) ? victim_line(tag_q, line_q[5:0])
                     : (state == S_FILL) ? line_q : 11'd0;
    assign mem_wdata = (state == S_WB) ? buf_q : 64'd0;
    assign inv_out   = (state == S_UPG) || (state == S_INV);
    assign inv_addr  = inv_out ? line_q : 11'd0;
    assign bus_req   = bus_req_q;
    assign cpu_rdy   = (state == S_DONE);
    assign cpu_err   = (state == S_DONE) && err_q;
    assign cpu_rdata = (state == S_DONE && !is_wr_q && !err_q) ? buf_q[{wsel_q, 4'b0000} +: 16] : 16'd0;

endmodule

// File: tb/tb_msi_cache_ctrl.sv
// tb/tb_msi_cache_ctrl.sv - scoreboard bench for msi_cache_ctrl with cache and memory models
module tb_msi_cache_ctrl;
    import msi_cache_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_rdy, cpu_err;
    logic [10:0] c_addr;
    logic        c_re, c_we;
    logic [1:0]  c_wstate;
    logic [63:0] c_wdata;
    logic        c_hit, c_dirty;
    logic [1:0]  c_rstate;
    logic [63:0] c_rdata;
    logic [4:0]  c_tag;
    logic        mem_re, mem_we;
    logic [10:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_rdy = 1'b0;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic        inv_out;
    logic [10:0] inv_addr;

    msi_cache_ctrl #(.MEM_TO(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy), .cpu_err(cpu_err),
        .c_addr(c_addr), .c_re(c_re), .c_we(c_we), .c_wstate(c_wstate), .c_wdata(c_wdata),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_rstate(c_rstate), .c_rdata(c_rdata), .c_tag(c_tag),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .inv_out(inv_out), .inv_addr(inv_addr)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    int n_busreq = 0, n_memre = 0, n_cwe = 0, n_inv = 0;
    int gnt_dly = 2, mem_lat = 3;
    bit mem_en = 1'b1;
    logic [63:0] mem_fill = '0;

    // Cache array model
    logic [4:0]  m_tag [64];
    logic [1:0]  m_st  [64];
    logic [63:0] m_data[64];
    assign c_hit    = (m_st[c_addr[5:0]] != 2'd0) && (m_tag[c_addr[5:0]] == c_addr[10:6]);
    assign c_dirty  = (m_st[c_addr[5:0]] == 2'd2);
    assign c_rstate = m_st[c_addr[5:0]];
    assign c_rdata  = m_data[c_addr[5:0]];
    assign c_tag    = m_tag[c_addr[5:0]];

    // Scoreboard queues: rsp = {check_data, err, rdata}
    logic [17:0] exp_rsp[$];
    logic [76:0] exp_cw[$];
    logic [10:0] exp_inv[$];
    logic [74:0] exp_mw[$];
    logic [10:0] exp_mr[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=unexpected_output required=none", name);
    endtask

    task automatic preload(input int idx, input logic [4:0] tag, input logic [1:0] st, input logic [63:0] d);
        m_tag[idx] = tag; m_st[idx] = st; m_data[idx] = d;
    endtask

    task automatic clr_counts();
        n_busreq = 0; n_memre = 0; n_cwe = 0; n_inv = 0;
    endtask

    task automatic cpu_req(input logic rd, input logic wr, input logic [12:0] a, input logic [15:0] d,
                           output int lat);
        int t0;
        bit seen;
        @(posedge clk); #1;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        t0 = cyc; seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (cpu_rdy) seen = 1;
        end
        lat = cyc - t0 + 1;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL req_timeout actual=no_cpu_rdy required=cpu_rdy addr=%0h", a);
        end
        @(posedge clk); #1;
        cpu_rd = 0; cpu_wr = 0;
    endtask

    initial forever begin @(posedge clk); cyc++; end

    initial begin : gnt_resp
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (bus_req) begin n++; if (n > gnt_dly) bus_gnt = 1'b1; end
            else begin n = 0; bus_gnt = 1'b0; end
        end
    end

    initial begin : mem_resp
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_rdy) begin mem_rdy = 1'b0; n = 0; end
            else if ((mem_re || mem_we) && mem_en) begin
                n++;
                if (n >= mem_lat) begin mem_rdy = 1'b1; mem_rdata = mem_fill; end
            end else n = 0;
        end
    end

    initial begin : monitor
        logic [17:0] r;
        logic [76:0] w;
        logic [74:0] m;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_req) n_busreq++;
                if (mem_re)  n_memre++;
                if (c_we)    n_cwe++;
                if (cpu_rdy) begin
                    if (exp_rsp.size() == 0) unexpected("cpu_rdy");
                    else begin
                        r = exp_rsp.pop_front();
                        check("rsp_err", cpu_err, r[16]);
                        if (r[17]) check("rsp_rdata", cpu_rdata, r[15:0]);
                    end
                end else if (cpu_err) unexpected("cpu_err_without_rdy");
                if (c_we) begin
                    if (exp_cw.size() == 0) unexpected("cache_write");
                    else begin
                        w = exp_cw.pop_front();
                        check("cw_line", {c_addr, c_wstate, c_wdata}, w);
                    end
                    m_tag[c_addr[5:0]] = c_addr[10:6];
                    m_st[c_addr[5:0]] = c_wstate;
                    m_data[c_addr[5:0]] = c_wdata;
                end
                if (inv_out) begin
                    n_inv++;
                    if (exp_inv.size() == 0) unexpected("inv_out");
                    else check("inv_addr", inv_addr, exp_inv.pop_front());
                end
                if (mem_we && mem_rdy) begin
                    if (exp_mw.size() == 0) unexpected("mem_write");
                    else begin
                        m = exp_mw.pop_front();
                        check("mem_wb", {mem_addr, mem_wdata}, m);
                    end
                end
                if (mem_re && mem_rdy) begin
                    if (exp_mr.size() == 0) unexpected("mem_read");
                    else check("mem_fill_addr", mem_addr, exp_mr.pop_front());
                end
            end
        end
    end

    initial begin : stim
        int lat;
        bit seen;
        for (int i = 0; i < 64; i++) preload(i, 5'd0, INVALID, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {cpu_rdy, cpu_err, bus_req, c_re, c_we, c_wstate, mem_re, mem_we,
                                inv_out, c_addr, mem_addr, cpu_rdata}, 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Read hit on SHARED line
        preload(1, 5'd1, SHARED, 64'h4444_3333_2222_1111);
        clr_counts();
        exp_rsp.push_back({1'b1, 1'b0, 16'h3333});
        cpu_req(1, 0, {11'h041, 2'b10}, 16'h0, lat);
        check("rd_hit_latency", lat, 3);
        check("rd_hit_no_bus_req", n_busreq, 0);
        check("rd_hit_no_mem_re", n_memre, 0);

        // Write hit on SHARED line -> upgrade with invalidate
        clr_counts();
        exp_inv.push_back(11'h041);
        exp_cw.push_back({11'h041, MODIFIED, 64'h4444_3333_2222_BEEF});
        exp_rsp.push_back({1'b0, 1'b0, 16'h0});
        cpu_req(0, 1, {11'h041, 2'b00}, 16'hBEEF, lat);
        check("upg_inv_count", n_inv, 1);

        // Write hit on MODIFIED line
        clr_counts();
        exp_cw.push_back({11'h041, MODIFIED, 64'h4444_3333_CAFE_BEEF});
        exp_rsp.push_back({1'b0, 1'b0, 16'h0});
        cpu_req(0, 1, {11'h041, 2'b01}, 16'hCAFE, lat);
        check("wr_hit_mod_latency", lat, 4);
        check("wr_hit_mod_no_bus_req", n_busreq, 0);

        // Dirty miss: writeback of tag 3 then refill
        preload(1, 5'd3, MODIFIED, 64'h0123_4567_89AB_CDEF);
        mem_fill = 64'hAAAA_BBBB_CCCC_DDDD;
        exp_mw.push_back({11'h0C1, 64'h0123_4567_89AB_CDEF});
        exp_mr.push_back(11'h041);
        exp_cw.push_back({11'h041, SHARED, 64'hAAAA_BBBB_CCCC_DDDD});
        exp_rsp.push_back({1'b1, 1'b0, 16'hCCCC});
        cpu_req(1, 0, {11'h041, 2'b01}, 16'h0, lat);

        // Write miss on clean line
        preload(2, 5'd5, SHARED, 64'h9999_9999_9999_9999);
        mem_fill = 64'h5555_6666_7777_8888;
        clr_counts();
        exp_mr.push_back(11'h082);
        exp_cw.push_back({11'h082, MODIFIED, 64'h1234_6666_7777_8888});
        exp_inv.push_back(11'h082);
        exp_rsp.push_back({1'b0, 1'b0, 16'h0});
        cpu_req(0, 1, {11'h082, 2'b11}, 16'h1234, lat);
        check("wr_miss_inv_count", n_inv, 1);

        // Read and write together behave as a write
        exp_cw.push_back({11'h082, MODIFIED, 64'h1234_6666_7777_0F0F});
        exp_rsp.push_back({1'b0, 1'b0, 16'h0});
        cpu_req(1, 1, {11'h082, 2'b00}, 16'h0F0F, lat);

        // Memory timeout
        mem_en = 1'b0;
        clr_counts();
        exp_rsp.push_back({1'b0, 1'b1, 16'h0});
        cpu_req(1, 0, {11'h0C3, 2'b00}, 16'h0, lat);
        check("timeout_mem_re_cycles", n_memre, 8);
        check("timeout_no_cache_write", n_cwe, 0);

        // Asynchronous reset in the middle of a fill
        @(posedge clk); #1;
        cpu_rd = 1'b1; cpu_addr = {11'h0C4, 2'b00};
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (mem_re) seen = 1;
        end
        check("pre_reset_fill_active", {seen, bus_req}, 2'b11);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_fill", {bus_req, mem_re, cpu_rdy}, 3'b000);
        cpu_rd = 1'b0;
        mem_en = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;

        // Normal read hit after reset
        exp_rsp.push_back({1'b1, 1'b0, 16'hAAAA});
        cpu_req(1, 0, {11'h041, 2'b11}, 16'h0, lat);
        check("post_reset_rd_latency", lat, 3);

        repeat (5) @(posedge clk);
        check("scoreboard_drained",
              exp_rsp.size() + exp_cw.size() + exp_inv.size() + exp_mw.size() + exp_mr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=stuck required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msi_cache_ctrl.md
Name: msi_cache_ctrl

Overview:
Per-core controller that sequences one msi_cache array, main memory and the shared coherence bus. It takes CPU word reads and writes, resolves hits and misses, handles dirty-line writeback and refill, and performs MSI upgrades. Upgrades and write misses broadcast an invalidate to the peer cache. It sits between the core's memory stage and msi_cache. Ownership of the bus is requested from the system bus arbiter.

Parameters:
MEM_TO, 255, cycles to wait for mem_rdy before the access is aborted with cpu_err.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_rd  in  1  word read request; held until cpu_rdy
cpu_wr  in  1  word write request; held until cpu_rdy
cpu_addr  in  13  word address; [12:2] line address, [1:0] word select
cpu_wdata  in  16  write word
cpu_rdata  out  16  read word, valid while cpu_rdy
cpu_rdy  out  1  one-cycle completion pulse
cpu_err  out  1  one-cycle pulse with cpu_rdy on memory timeout
c_addr  out  11  cache line address
c_re  out  1  cache read enable
c_we  out  1  cache write enable
c_wstate  out  2  blk_state_t written to cache
c_wdata  out  64  line written to cache
c_hit  in  1  cache hit
c_dirty  in  1  cache line is MODIFIED
c_rstate  in  2  state of the line read
c_rdata  in  64  line read
c_tag  in  5  tag of the resident line, used for eviction
mem_re  out  1  memory line read
mem_we  out  1  memory line write
mem_addr  out  11  memory line address
mem_wdata  out  64  writeback line
mem_rdata  in  64  fill line
mem_rdy  in  1  memory access complete (one-cycle pulse)
bus_req  out  1  coherence bus request
bus_gnt  in  1  coherence bus grant
inv_out  out  1  one-cycle invalidate broadcast to peer cache
inv_addr  out  11  line address of the invalidate

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; every output 0, including c_wstate = INVALID.
- Line word n occupies bits [16n+15:16n]. c_addr always equals the captured cpu_addr[12:2].
- IDLE: on cpu_rd or cpu_wr, capture address, data and operation, then go to CMP. If both are asserted, treat the request as a write.
- CMP (c_re=1 for one cycle). Decisions are evaluated at the end of the cycle:
  - hit and read: DONE.
  - hit and write, rstate MODIFIED: WRITE.
  - hit and write, rstate SHARED: ARB, then UPG.
  - miss, resident line MODIFIED (c_dirty): ARB, then WB.
  - miss, resident line clean or INVALID: ARB, then FILL.
- ARB: assert bus_req and wait for bus_gnt. bus_req stays high from ARB until the return to IDLE, so peer invalidates cannot interleave with this transaction.
- UPG: inv_out=1 and inv_addr = line address for exactly one cycle, then WRITE.
- WB: mem_we=1, mem_addr = {c_tag, index}, mem_wdata = latched line. Hold until mem_rdy, then FILL.
- FILL: mem_re=1 with mem_addr = line address; hold until mem_rdy. On mem_rdy:
  - read: c_we=1, c_wstate=SHARED, c_wdata=mem_rdata; then DONE.
  - write: c_wdata = mem_rdata with the selected word replaced by cpu_wdata, c_wstate=MODIFIED; then INV, which pulses inv_out for one cycle and goes to DONE.
- WRITE: c_we=1 for one cycle, c_wstate=MODIFIED, c_wdata = latched c_rdata with the word merged; then DONE.
- DONE: cpu_rdy=1 for one cycle. For a read, cpu_rdata = the selected word of the latched or filled line. Drop bus_req and return to IDLE.
- Timeout: a counter runs in WB and FILL and clears on state entry. At MEM_TO cycles without mem_rdy:
  - drop mem_re/mem_we;
  - leave the cache unwritten;
  - cpu_rdy and cpu_err pulse together;
  - return to IDLE.
- c_we is held stable for one full cycle, which satisfies the cache glitch filter.
- Latency:
  - read hit: 3 cycles from request to cpu_rdy;
  - write hit on MODIFIED: 4 cycles;
  - misses: add arbitration and memory time.

Decomposition:
- blk_state_t {INVALID=0, SHARED=1, MODIFIED=2} is already in common; the controller state enum ctrl_state_t is added there.
- Sub-module word_merge: combinational 64-bit line plus 16-bit word insert by 2-bit select. It is shared by FILL and WRITE.

Test Plan:
- Read hit: preload line 0x041 SHARED, data 0x4444_3333_2222_1111; cpu_rd addr {0x041,2'b10} -> cpu_rdata 0x3333 with cpu_rdy at cycle 3; no bus_req and no mem_re.
- Write hit SHARED: same line, cpu_wr word 0 = 0xBEEF, bus_gnt after 2 cycles -> one inv_out pulse with inv_addr 0x041, then cache written MODIFIED with word0 0xBEEF.
- Dirty miss: index 1 holds tag 3 MODIFIED; cpu_rd line 0x041 -> mem_we to addr 0x0C1 with the old line, then mem_re 0x041, fill SHARED, cpu_rdata from mem_rdata.
- Write miss: clean line; cpu_wr word3 = 0x1234 -> FILL, cache line MODIFIED with [63:48] = 0x1234, inv_out pulse, cpu_rdy.
- Timeout: MEM_TO=8, mem_rdy never asserted -> mem_re drops after 8 cycles, cpu_rdy and cpu_err pulse together, c_we never asserted.
- Reset during FILL: rst_n low -> bus_req, mem_re and cpu_rdy go 0 immediately; after release the FSM is in IDLE and a new read completes normally.
